mem_arbiter: RTL and testbench

- Shares one single-port memory between the core's instruction-fetch requester and its load/store (data) requester.
- Sits between the cpu top level and the unified RAM. It serialises requests, holds each memory request until the memory's valid handshake, and returns data to the winning requester.
- Data accesses have priority. A starvation counter guarantees fetch progress, and a timeout counter recovers from a memory that never answers.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_counter.sv | 33 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// FSM and grant encodings plus counter sizing helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_e;

  localparam int STARVE_MAX_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// slave is the arbiter's view, master the environment's.
interface mem_arbiter_if;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic [31:0] if_rdata_out;
  logic        if_valid_out;
  logic        dm_req_in;
  logic [31:0] dm_addr_in;
  logic [31:0] dm_wdata_in;
  logic [3:0]  dm_byte_en_in;
  logic [31:0] dm_rdata_out;
  logic        dm_valid_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_byte_en_out;
  logic [31:0] mem_rdata_in;
  logic        mem_valid_in;
  logic        hold_flag_out;
  logic        err_out;

  modport slave (
    input  if_req_in, if_addr_in,
    output if_rdata_out, if_valid_out,
    input  dm_req_in, dm_addr_in,
    input  dm_wdata_in, dm_byte_en_in,
    output dm_rdata_out, dm_valid_out,
    output mem_req_out, mem_addr_out,
    output mem_wdata_out, mem_byte_en_out,
    input  mem_rdata_in, mem_valid_in,
    output hold_flag_out, err_out
  );

  modport master (
    output if_req_in, if_addr_in,
    input  if_rdata_out, if_valid_out,
    output dm_req_in, dm_addr_in,
    output dm_wdata_in, dm_byte_en_in,
    input  dm_rdata_out, dm_valid_out,
    input  mem_req_out, mem_addr_out,
    input  mem_wdata_out, mem_byte_en_out,
    output mem_rdata_in, mem_valid_in,
    input  hold_flag_out, err_out
  );
endinterface

// File: rtl/mem_arbiter_counter.sv
// Clearable saturating up-counter with a terminal flag.
// Used for both fetch starvation and memory timeout.
module arb_timeout_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W  = cnt_w(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != W'(MAX))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data requesters.
// Data wins unless fetch has been starved; a timeout aborts dead accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX     = STARVE_MAX_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_e      state_q, state_d;
  grant_e      grant;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        dm_valid_q, dm_valid_d;
  logic        err_q, err_d;
  logic [31:0] rsp_data;
  logic        starve_term, tmo_term;
  logic        starve_clr, starve_inc;
  logic        tmo_clr, tmo_inc;
  logic        busy, dm_win, if_win;

  assign busy   = (state_q == IF_BUSY) ||
                  (state_q == DM_BUSY);
  assign dm_win = bus.dm_req_in &&
                  !(bus.if_req_in && starve_term);
  assign if_win = bus.if_req_in && !dm_win;

  always_comb begin
    grant = GNT_NONE;
    if (state_q == IDLE) begin
      unique case (1'b1)
        dm_win:  grant = GNT_DM;
        if_win:  grant = GNT_IF;
        default: grant = GNT_NONE;
      endcase
    end
  end

  assign starve_inc = (grant == GNT_DM) && bus.if_req_in;
  assign starve_clr = (grant == GNT_IF) ||
                      ((grant == GNT_DM) && !bus.if_req_in);
  assign tmo_clr    = (grant != GNT_NONE);
  assign tmo_inc    = busy && !bus.mem_valid_in;

  arb_timeout_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (starve_clr),
    .inc_i  (starve_inc),
    .term_o (starve_term)
  );

  // Terminal one short of the limit so the abort lands on the Nth busy edge
  arb_timeout_counter #(
    .MAX (TIMEOUT_CYCLES - 1)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmo_clr),
    .inc_i  (tmo_inc),
    .term_o (tmo_term)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = 1'b0;
    rsp_data    = bus.mem_valid_in ?
                  bus.mem_rdata_in : 32'd0;
    unique case (state_q)
      IDLE: begin
        unique case (grant)
          GNT_DM: begin
            state_d     = DM_BUSY;
            mem_req_d   = 1'b1;
            mem_addr_d  = bus.dm_addr_in;
            mem_wdata_d = bus.dm_wdata_in;
            mem_be_d    = bus.dm_byte_en_in;
          end
          GNT_IF: begin
            state_d     = IF_BUSY;
            mem_req_d   = 1'b1;
            mem_addr_d  = bus.if_addr_in;
            mem_wdata_d = 32'd0;
            mem_be_d    = 4'd0;
          end
          default: ;
        endcase
      end
      IF_BUSY, DM_BUSY: begin
        // A real answer beats a coincident timeout
        if (bus.mem_valid_in || tmo_term) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = !bus.mem_valid_in;
          if (state_q == IF_BUSY) begin
            if_valid_d = 1'b1;
            if_rdata_d = rsp_data;
          end else begin
            dm_valid_d = 1'b1;
            dm_rdata_d = rsp_data;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req_out     = mem_req_q;
  assign bus.mem_addr_out    = mem_addr_q;
  assign bus.mem_wdata_out   = mem_wdata_q;
  assign bus.mem_byte_en_out = mem_be_q;
  assign bus.if_rdata_out    = if_rdata_q;
  assign bus.if_valid_out    = if_valid_q;
  assign bus.dm_rdata_out    = dm_rdata_q;
  assign bus.dm_valid_out    = dm_valid_q;
  assign bus.err_out         = err_q;
  assign bus.hold_flag_out   =
    (bus.if_req_in && !if_valid_q) ||
    (bus.dm_req_in && !dm_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, memory model and scoreboards.
// Expected memory requests and completions are queued at drive time.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_MAX     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    bit          err;
  } cmpl_t;

  typedef struct {
    bit          ifr;
    logic [31:0] ia;
    bit          dmr;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  be;
    int          lat;
    bit          dm_first;
  } vec_t;

  mreq_t mq[$];
  cmpl_t cq[$];
  vec_t  vt[7];

  int nvec = 0;
  int nerr = 0;
  int ncomp = 0;
  int mem_lat = 0;
  int mem_cnt = 0;
  int hi_cnt = 0;
  int last_hi = 0;
  bit mem_en = 1'b1;
  bit auto_clr = 1'b1;
  bit prev_req = 1'b0;
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  function automatic logic [31:0] mem_model(
    input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a ^ 32'hC3A5_5A3C) + 32'h11;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic push_dm(input logic [31:0] a,
                         input logic [31:0] w,
                         input logic [3:0] be,
                         input logic [31:0] rd,
                         input bit err);
    mreq_t m;
    cmpl_t c;
    m = '{a, w, be};
    c = '{1'b1, rd, err};
    mq.push_back(m);
    cq.push_back(c);
  endtask

  task automatic push_if(input logic [31:0] a,
                         input logic [31:0] rd);
    mreq_t m;
    cmpl_t c;
    m = '{a, 32'd0, 4'd0};
    c = '{1'b0, rd, 1'b0};
    mq.push_back(m);
    cq.push_back(c);
  endtask

  // One cycle: scoreboard checks, then the memory model reacts
  task automatic step();
    cmpl_t e;
    mreq_t m;
    @(negedge clk);
    if (bus.if_valid_out || bus.dm_valid_out) begin
      if (cq.size() == 0) begin
        chk("unexpected_valid",
            {30'd0, bus.dm_valid_out, bus.if_valid_out},
            32'd0);
      end else begin
        e = cq.pop_front();
        chk("valid_sel",
            {30'd0, bus.dm_valid_out, bus.if_valid_out},
            e.is_dm ? 32'd2 : 32'd1);
        chk(e.is_dm ? "dm_rdata" : "if_rdata",
            e.is_dm ? bus.dm_rdata_out : bus.if_rdata_out,
            e.rdata);
        chk("err", 32'(bus.err_out), 32'(e.err));
        if (e.is_dm) last_dm = e.rdata;
        else         last_if = e.rdata;
      end
      ncomp++;
      if (auto_clr) begin
        if (bus.if_valid_out) bus.if_req_in = 1'b0;
        if (bus.dm_valid_out) bus.dm_req_in = 1'b0;
      end
    end
    if (bus.mem_req_out && !prev_req) begin
      if (mq.size() == 0) begin
        chk("unexpected_mem_req", 32'd1, 32'd0);
      end else begin
        m = mq.pop_front();
        chk("mem_addr", bus.mem_addr_out, m.addr);
        chk("mem_be", 32'(bus.mem_byte_en_out),
            32'(m.be));
        if (m.be != 4'd0)
          chk("mem_wdata", bus.mem_wdata_out, m.wdata);
      end
    end
    if (bus.mem_req_out) begin
      hi_cnt++;
    end else if (prev_req) begin
      last_hi = hi_cnt;
      hi_cnt  = 0;
    end
    prev_req = bus.mem_req_out;
    if (bus.mem_valid_in) begin
      bus.mem_valid_in = 1'b0;
    end else if (mem_en && bus.mem_req_out) begin
      if (mem_lat >= 0 && mem_cnt == mem_lat) begin
        bus.mem_valid_in = 1'b1;
        bus.mem_rdata_in = mem_model(bus.mem_addr_out);
        mem_cnt = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int b;
    b = 0;
    while ((bus.if_req_in || bus.dm_req_in) && b < 100) begin
      step();
      b++;
    end
    chk(nm, 32'(bus.if_req_in || bus.dm_req_in), 32'd0);
    bus.if_req_in = 1'b0;
    bus.dm_req_in = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    mem_lat = v.lat;
    if (v.dm_first) begin
      if (v.dmr) push_dm(v.da, v.dw, v.be, mem_model(v.da), 1'b0);
      if (v.ifr) push_if(v.ia, mem_model(v.ia));
    end else begin
      if (v.ifr) push_if(v.ia, mem_model(v.ia));
      if (v.dmr) push_dm(v.da, v.dw, v.be, mem_model(v.da), 1'b0);
    end
    bus.if_req_in     = v.ifr;
    bus.if_addr_in    = v.ia;
    bus.dm_req_in     = v.dmr;
    bus.dm_addr_in    = v.da;
    bus.dm_wdata_in   = v.dw;
    bus.dm_byte_en_in = v.be;
    step();
    chk("hold_pending", 32'(bus.hold_flag_out), 32'd1);
    wait_idle("vec_done");
    step();
    chk("hold_idle", 32'(bus.hold_flag_out), 32'd0);
    chk("if_rdata_hold", bus.if_rdata_out, last_if);
    chk("dm_rdata_hold", bus.dm_rdata_out, last_dm);
    chk("queues_drained", 32'(cq.size() + mq.size()), 32'd0);
    cq.delete();
    mq.delete();
  endtask

  initial begin
    int target;
    int b;
    vt[0] = '{1'b1, 32'h100, 1'b0, 32'h0, 32'h0,
              4'h0, 2, 1'b0};
    vt[1] = '{1'b1, 32'h104, 1'b1, 32'h2000,
              32'hDEAD_BEEF, 4'hF, 1, 1'b1};
    vt[2] = '{1'b0, 32'h0, 1'b1, 32'h40, 32'h0,
              4'h0, 0, 1'b1};
    vt[3] = '{1'b0, 32'h0, 1'b1, 32'h44,
              32'h1122_3344, 4'h2, 3, 1'b1};
    vt[4] = '{1'b1, 32'h108, 1'b1, 32'h80, 32'h0,
              4'h0, 0, 1'b1};
    vt[5] = '{1'b0, 32'h0, 1'b1, 32'h3100, 32'h0,
              4'h0, 15, 1'b1};
    vt[6] = '{1'b1, 32'h10C, 1'b0, 32'h0, 32'h0,
              4'h0, 14, 1'b0};

    bus.if_req_in     = 1'b0;
    bus.if_addr_in    = '0;
    bus.dm_req_in     = 1'b0;
    bus.dm_addr_in    = '0;
    bus.dm_wdata_in   = '0;
    bus.dm_byte_en_in = '0;
    bus.mem_rdata_in  = '0;
    bus.mem_valid_in  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req_out), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_out, 32'd0);
    chk("rst_mem_be", 32'(bus.mem_byte_en_out), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid_out), 32'd0);
    chk("rst_dm_valid", 32'(bus.dm_valid_out), 32'd0);
    chk("rst_if_rdata", bus.if_rdata_out, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata_out, 32'd0);
    chk("rst_err", 32'(bus.err_out), 32'd0);
    chk("rst_hold", 32'(bus.hold_flag_out), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Timeout: memory never answers a load
    mem_lat = -1;
    push_dm(32'h3000, 32'h0, 4'h0, 32'h0, 1'b1);
    bus.dm_req_in     = 1'b1;
    bus.dm_addr_in    = 32'h3000;
    bus.dm_wdata_in   = 32'h0;
    bus.dm_byte_en_in = 4'h0;
    wait_idle("timeout_done");
    chk("timeout_req_cycles", 32'(last_hi), 32'd16);
    chk("timeout_rdata_hold", bus.dm_rdata_out, 32'd0);
    step();
    step();
    mem_lat = 0;
    run_vec(2);

    // Reset while a data access is outstanding
    mem_en = 1'b0;
    push_dm(32'h3004, 32'h0, 4'h0, 32'h0, 1'b0);
    cq.delete();
    bus.dm_req_in  = 1'b1;
    bus.dm_addr_in = 32'h3004;
    step();
    step();
    chk("busy_before_rst", 32'(bus.mem_req_out), 32'd1);
    rst = 1'b1;
    bus.dm_req_in = 1'b0;
    step();
    chk("midrst_mem_req", 32'(bus.mem_req_out), 32'd0);
    chk("midrst_mem_addr", bus.mem_addr_out, 32'd0);
    chk("midrst_dm_valid", 32'(bus.dm_valid_out), 32'd0);
    chk("midrst_dm_rdata", bus.dm_rdata_out, 32'd0);
    chk("midrst_if_rdata", bus.if_rdata_out, 32'd0);
    chk("midrst_hold", 32'(bus.hold_flag_out), 32'd0);
    last_if = '0;
    last_dm = '0;
    rst = 1'b0;
    step();
    bus.mem_valid_in = 1'b1;
    bus.mem_rdata_in = 32'hBAD0_BAD0;
    step();
    chk("stray_dm_valid", 32'(bus.dm_valid_out), 32'd0);
    chk("stray_mem_req", 32'(bus.mem_req_out), 32'd0);
    step();
    chk("stray_dm_valid2", 32'(bus.dm_valid_out), 32'd0);
    chk("stray_dm_rdata", bus.dm_rdata_out, 32'd0);
    mem_en = 1'b1;

    // Starvation: both held high, expect DM x4 then IF, twice
    auto_clr = 1'b0;
    mem_lat  = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) push_if(32'h600, mem_model(32'h600));
      else push_dm(32'h500, 32'h0, 4'h0,
                   mem_model(32'h500), 1'b0);
    end
    bus.dm_req_in     = 1'b1;
    bus.dm_addr_in    = 32'h500;
    bus.dm_byte_en_in = 4'h0;
    bus.if_req_in     = 1'b1;
    bus.if_addr_in    = 32'h600;
    target = ncomp + 10;
    b = 0;
    while (ncomp < target && b < 300) begin
      step();
      b++;
    end
    bus.dm_req_in = 1'b0;
    bus.if_req_in = 1'b0;
    chk("starve_count", 32'(ncomp), 32'(target));
    auto_clr = 1'b1;
    step();
    step();
    chk("starve_drained", 32'(cq.size()), 32'd0);

    // Fetch withdrawn one cycle after its grant
    mem_lat = 4;
    push_if(32'h200, mem_model(32'h200));
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h200;
    step();
    chk("wd_hold_pending", 32'(bus.hold_flag_out), 32'd1);
    bus.if_req_in = 1'b0;
    target = ncomp + 1;
    b = 0;
    while (ncomp < target && b < 50) begin
      step();
      b++;
    end
    chk("wd_completed", 32'(ncomp), 32'(target));
    step();
    chk("wd_hold_idle", 32'(bus.hold_flag_out), 32'd0);
    chk("wd_if_rdata", bus.if_rdata_out, mem_model(32'h200));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
